mips_dmem_port: RTL and testbench
=================================

Name: mips_dmem_port

Overview:
- MEM-stage initiator for the MIPS pipeline's byte-lane data memory: four 8-bit banks with 512 entries each.
- Converts one pipeline load/store request (byte, halfword or word; signed or unsigned) into per-lane rd_en/wr_en strobes with a shared 9-bit word address.
- Captures the lane read data, steers it into place and sign/zero-extends it, then returns a single-cycle response.
- Holds off the pipeline via req_ready while an access is in flight.

Parameters:
ADDR_W, 11, byte address width; lane address is ADDR_W-2 = 9 bits (512 words).

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at posedge
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid
mem_rd_en  out  4  per-lane read strobe; lane k holds word bits [8k+7:8k]
mem_wr_en  out  4  per-lane write strobe
mem_addr  out  9  shared lane address = req_addr[ADDR_W-1:2]
mem_wdata  out  32  lane k data at [8k+7:8k]
mem_rdata  in  32  lane k data_out at [8k+7:8k]
mem_valid  in  4  lane valid_out flags

Behaviour:
- Reset values: req_ready=0 while rst is high, 1 on the first cycle after. resp_valid=0, resp_err=0, resp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0. State=IDLE.
- Big-endian lane mapping: byte offset o=req_addr[1:0] lives in lane 3-o.
  - Byte access: one lane.
  - Half at offset 0: lanes 3,2. Half at offset 2: lanes 1,0.
  - Word access: all four lanes.
- Alignment rules:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - size=11 is illegal.
  - Any of these produces an error response and no lane strobes.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. req_ready=1 only in IDLE. All mem_* outputs are registered.
- IDLE: on accept, latch we/size/signed/offset.
  - Legal request: drive mem_addr, lane enables and steered mem_wdata for the next cycle, then go to ACCESS.
  - Illegal request: go to RESP with err=1.
- ACCESS (1 cycle): lane strobes are high here and the lanes sample at the end of the cycle. Strobes are cleared on leaving.
  - Store: go to RESP, err=0.
  - Load: go to CAPTURE.
- CAPTURE (1 cycle): every enabled lane must show mem_valid=1; otherwise err=1.
  - Select lane bytes from mem_rdata, right-align, and extend: byte→bit 7, half→bit 15, word unchanged.
  - Register the result, then go to RESP.
- RESP (1 cycle): resp_valid=1 with resp_rdata/resp_err, then go to IDLE. resp_valid returns to 0 in IDLE.
- Latency, with accept at the edge ending cycle 0:
  - Load: resp_valid in cycle 3.
  - Store: resp_valid in cycle 2.
  - Error: resp_valid in cycle 1.
  - Next accept is possible at the edge ending the cycle after RESP; throughput is one load per 4 cycles.
- mem_rd_en and mem_wr_en are never both nonzero. Lanes not enabled for a store keep mem_wdata=0.
- req_valid deasserting while busy is ignored; the latched request completes.
- Reset mid-operation, in any state: next cycle is IDLE, strobes are 0, and no response pulse for the aborted request. An in-flight lane write already sampled at that edge stands.
- mem_valid outside CAPTURE is ignored.

Test Plan:
- sw req_wdata=0x12345678 to addr 0x010, then lw 0x010 → mem_wr_en=1111, mem_addr=0x004, mem_wdata=0x12345678 in cycle 1; store resp_valid in cycle 2; load resp_rdata=0x12345678, resp_err=0, resp_valid in cycle 3 after its accept.
- After the above: lb signed 0x011 → mem_rd_en=0100, resp_rdata=0x00000034. lhu 0x012 → mem_rd_en=0011, resp_rdata=0x00005678.
- sb 0x80 to 0x013 → mem_wr_en=0001, mem_wdata=0x00000080. Then lb signed 0x013 → 0xFFFFFF80; lbu 0x013 → 0x00000080; lh signed 0x012 → 0x00005680.
- lh 0x011, lw 0x012, and size=11 at 0x010 → resp_valid with resp_err=1, resp_rdata=0, in cycle 1; mem_rd_en/mem_wr_en stay 0000 throughout.
- Load 0x010 with mem_valid forced to 0000 in CAPTURE → resp_err=1. Separately, assert rst during ACCESS → cycle after: strobes 0000, resp_valid never pulses, req_ready=1 once rst drops.
- Back-to-back req_valid held high for 3 loads → each accept is spaced 4 cycles apart, req_ready=0 in ACCESS/CAPTURE/RESP, responses in order.

Source files
------------

// File: rtl/mips_dmem_port.sv
// MEM-stage initiator for the byte-lane data memory (four 8-bit banks, big-endian lanes).
// Turns one load/store request into lane strobes, then returns an extended load result.
module mips_dmem_port #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        mem_rd_en,
  output logic [3:0]        mem_wr_en,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [3:0]        mem_valid
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t state, state_d;

  logic              op_we, op_we_d;
  logic [1:0]        op_size, op_size_d;
  logic              op_signed, op_signed_d;
  logic [1:0]        op_off, op_off_d;
  logic [3:0]        op_lanes, op_lanes_d;

  logic [3:0]        mem_rd_en_d, mem_wr_en_d;
  logic [ADDR_W-3:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              resp_valid_d, resp_err_d;
  logic [31:0]       resp_rdata_d;

  logic [3:0]        req_lanes;
  logic              req_bad;
  logic [31:0]       req_steered;
  logic [31:0]       lane_mask;

  logic [4:0]        rd_shift;
  logic [31:0]       rd_shifted;
  logic [31:0]       rd_ext;
  logic              capture_err;

  assign req_ready = (state == IDLE) && !rst;

  // Request decode: byte offset o lives in lane 3-o; misaligned or illegal sizes get no lanes.
  always_comb begin
    req_lanes = 4'b0000;
    req_bad   = 1'b0;
    case (req_size)
      2'b00: req_lanes = 4'b1000 >> req_addr[1:0];
      2'b01: begin
        req_bad   = req_addr[0];
        req_lanes = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        req_bad   = |req_addr[1:0];
        req_lanes = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
    if (req_bad) req_lanes = 4'b0000;
  end

  // Replicate right-aligned store data across lanes, then keep only the enabled ones.
  always_comb begin
    case (req_size)
      2'b00:   req_steered = {4{req_wdata[7:0]}};
      2'b01:   req_steered = {2{req_wdata[15:0]}};
      default: req_steered = req_wdata;
    endcase
    lane_mask = {{8{req_lanes[3]}}, {8{req_lanes[2]}}, {8{req_lanes[1]}}, {8{req_lanes[0]}}};
  end

  // Load alignment: shift the addressed lanes down to bit 0 and extend.
  always_comb begin
    case (op_size)
      2'b00:   rd_shift = {2'd3 - op_off, 3'b000};
      2'b01:   rd_shift = {2'd2 - op_off, 3'b000};
      default: rd_shift = 5'd0;
    endcase
    rd_shifted = mem_rdata >> rd_shift;
    case (op_size)
      2'b00:   rd_ext = {{24{op_signed & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   rd_ext = {{16{op_signed & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
    capture_err = |(op_lanes & ~mem_valid);
  end

  always_comb begin
    state_d      = state;
    op_we_d      = op_we;
    op_size_d    = op_size;
    op_signed_d  = op_signed;
    op_off_d     = op_off;
    op_lanes_d   = op_lanes;
    mem_rd_en_d  = mem_rd_en;
    mem_wr_en_d  = mem_wr_en;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_we_d     = req_we;
          op_size_d   = req_size;
          op_signed_d = req_signed;
          op_off_d    = req_addr[1:0];
          op_lanes_d  = req_lanes;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = req_addr[ADDR_W-1:2];
            if (req_we) begin
              mem_wr_en_d = req_lanes;
              mem_wdata_d = req_steered & lane_mask;
            end else begin
              mem_rd_en_d = req_lanes;
            end
          end
        end
      end
      ACCESS: begin
        mem_rd_en_d = 4'b0000;
        mem_wr_en_d = 4'b0000;
        mem_wdata_d = 32'd0;
        if (op_we) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = capture_err;
        resp_rdata_d = capture_err ? 32'd0 : rd_ext;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_we      <= 1'b0;
      op_size    <= 2'b00;
      op_signed  <= 1'b0;
      op_off     <= 2'b00;
      op_lanes   <= 4'b0000;
      mem_rd_en  <= 4'b0000;
      mem_wr_en  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_d;
      op_we      <= op_we_d;
      op_size    <= op_size_d;
      op_signed  <= op_signed_d;
      op_off     <= op_off_d;
      op_lanes   <= op_lanes_d;
      mem_rd_en  <= mem_rd_en_d;
      mem_wr_en  <= mem_wr_en_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_dmem_port.sv
// Directed bench for mips_dmem_port with a four-lane synchronous memory model behind it.
module tb_mips_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_rd_en, mem_wr_en, mem_valid;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [7:0]  lane_mem [4][512];
  logic [31:0] rdata_q;
  logic [3:0]  valid_q;
  logic        force_invalid;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  obs_rd1, obs_wr1, obs_strobes;
  logic [8:0]  obs_addr1;
  logic [31:0] obs_wdata1, obs_rdata;
  logic        obs_err, obs_both;
  int          obs_cycle;

  mips_dmem_port #(.ADDR_W(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // Lane banks: synchronous read with a valid flag one cycle after the read strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_wr_en[k]) lane_mem[k][mem_addr] <= mem_wdata[8*k +: 8];
      if (mem_rd_en[k]) rdata_q[8*k +: 8] <= lane_mem[k][mem_addr];
      valid_q[k] <= mem_rd_en[k];
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_valid = force_invalid ? 4'b0000 : valid_q;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Issues one request, records the cycle-1 strobes and the response with its cycle number.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [10:0] addr, input logic [31:0] wdata);
    int guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("ready_wait", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid   = 1'b0;
    obs_rd1     = mem_rd_en;
    obs_wr1     = mem_wr_en;
    obs_addr1   = mem_addr;
    obs_wdata1  = mem_wdata;
    obs_strobes = 4'b0000;
    obs_both    = 1'b0;
    obs_cycle   = 0;
    obs_rdata   = 32'hDEADBEEF;
    obs_err     = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      obs_strobes = obs_strobes | mem_rd_en | mem_wr_en;
      if ((|mem_rd_en) && (|mem_wr_en)) obs_both = 1'b1;
      if (resp_valid && obs_cycle == 0) begin
        obs_cycle = c;
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
      end
    end
  endtask

  task automatic checkLoad(input string tag, input logic [3:0] lanes, input logic [31:0] data);
    checkOutput({tag, "_rd_en"}, {28'd0, obs_rd1}, {28'd0, lanes});
    checkOutput({tag, "_wr_en"}, {28'd0, obs_wr1}, 32'd0);
    checkOutput({tag, "_cycle"}, obs_cycle, 32'd3);
    checkOutput({tag, "_rdata"}, obs_rdata, data);
    checkOutput({tag, "_err"}, {31'd0, obs_err}, 32'd0);
  endtask

  logic [1:0]  err_size  [3] = '{2'b01, 2'b10, 2'b11};
  logic [10:0] err_addr  [3] = '{11'h011, 11'h012, 11'h010};
  logic [1:0]  b2b_size  [3] = '{2'b10, 2'b00, 2'b01};
  logic        b2b_sgn   [3] = '{1'b0, 1'b1, 1'b0};
  logic [10:0] b2b_addr  [3] = '{11'h010, 11'h013, 11'h010};
  logic [31:0] b2b_exp   [3] = '{32'h12345680, 32'hFFFFFF80, 32'h00001234};

  initial begin
    int acc [3];
    int rsp [3];
    logic [31:0] rdv [3];
    int n, nr, pulses;
    logic upd;

    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 512; a++) lane_mem[k][a] = 8'h00;
    rdata_q = 32'd0;
    valid_q = 4'b0000;
    force_invalid = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_strobes", {24'd0, mem_rd_en, mem_wr_en}, 32'd0);
    checkOutput("rst_addr", {23'd0, mem_addr}, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    rst = 1'b0;
    #1 checkOutput("ready_after_rst", {31'd0, req_ready}, 32'd1);

    applyStimulus(1'b1, 2'b10, 1'b0, 11'h010, 32'h12345678);
    checkOutput("sw_wr_en", {28'd0, obs_wr1}, 32'hF);
    checkOutput("sw_rd_en", {28'd0, obs_rd1}, 32'h0);
    checkOutput("sw_addr", {23'd0, obs_addr1}, 32'h004);
    checkOutput("sw_wdata", obs_wdata1, 32'h12345678);
    checkOutput("sw_cycle", obs_cycle, 32'd2);
    checkOutput("sw_resp", {obs_rdata[30:0], obs_err}, 32'd0);

    applyStimulus(1'b0, 2'b10, 1'b0, 11'h010, 32'd0);
    checkLoad("lw_010", 4'b1111, 32'h12345678);
    checkOutput("lw_addr", {23'd0, obs_addr1}, 32'h004);
    applyStimulus(1'b0, 2'b00, 1'b1, 11'h011, 32'd0);
    checkLoad("lb_011", 4'b0100, 32'h00000034);
    applyStimulus(1'b0, 2'b01, 1'b0, 11'h012, 32'd0);
    checkLoad("lhu_012", 4'b0011, 32'h00005678);

    applyStimulus(1'b1, 2'b00, 1'b0, 11'h013, 32'hAAAAAA80);
    checkOutput("sb_wr_en", {28'd0, obs_wr1}, 32'h1);
    checkOutput("sb_wdata", obs_wdata1, 32'h00000080);
    checkOutput("sb_cycle", obs_cycle, 32'd2);

    applyStimulus(1'b0, 2'b00, 1'b1, 11'h013, 32'd0);
    checkLoad("lb_013", 4'b0001, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 11'h013, 32'd0);
    checkLoad("lbu_013", 4'b0001, 32'h00000080);
    applyStimulus(1'b0, 2'b01, 1'b1, 11'h012, 32'd0);
    checkLoad("lh_012", 4'b0011, 32'h00005680);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, err_size[i], 1'b1, err_addr[i], 32'd0);
      checkOutput($sformatf("err%0d_cycle", i), obs_cycle, 32'd1);
      checkOutput($sformatf("err%0d_err", i), {31'd0, obs_err}, 32'd1);
      checkOutput($sformatf("err%0d_rdata", i), obs_rdata, 32'd0);
      checkOutput($sformatf("err%0d_strobes", i), {28'd0, obs_strobes}, 32'd0);
    end
    applyStimulus(1'b1, 2'b01, 1'b0, 11'h011, 32'hFFFF);
    checkOutput("sh_misaligned_strobes", {28'd0, obs_strobes}, 32'd0);
    checkOutput("sh_misaligned_err", {31'd0, obs_err}, 32'd1);

    force_invalid = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 11'h010, 32'd0);
    force_invalid = 1'b0;
    checkOutput("invalid_cycle", obs_cycle, 32'd3);
    checkOutput("invalid_err", {31'd0, obs_err}, 32'd1);
    checkOutput("invalid_rdata", obs_rdata, 32'd0);
    checkOutput("never_both", {31'd0, obs_both}, 32'd0);

    // Reset while the load is in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 11'h010;
    checkOutput("rstmid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstmid_access_rd", {28'd0, mem_rd_en}, 32'hF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_strobes", {24'd0, mem_rd_en, mem_wr_en}, 32'd0);
    checkOutput("rstmid_ready_in_rst", {31'd0, req_ready}, 32'd0);
    pulses = resp_valid ? 1 : 0;
    rst = 1'b0;
    #1 checkOutput("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    checkOutput("rstmid_no_resp", pulses, 32'd0);

    // Three loads with req_valid held high throughout.
    n = 0; nr = 0; upd = 1'b0;
    for (int i = 0; i < 3; i++) begin acc[i] = -1; rsp[i] = -1; rdv[i] = 32'hDEADBEEF; end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0;
    req_size = b2b_size[0]; req_signed = b2b_sgn[0]; req_addr = b2b_addr[0];
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (upd) begin
        if (n < 3) begin
          req_size = b2b_size[n]; req_signed = b2b_sgn[n]; req_addr = b2b_addr[n];
        end else begin
          req_valid = 1'b0;
        end
        upd = 1'b0;
      end
      if (resp_valid && nr < 3) begin
        rsp[nr] = c; rdv[nr] = resp_rdata; nr++;
      end
      if (req_ready && req_valid && n < 3) begin
        acc[n] = c; n++; upd = 1'b1;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_spacing01", acc[1] - acc[0], 32'd4);
    checkOutput("b2b_spacing12", acc[2] - acc[1], 32'd4);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("b2b_latency%0d", i), rsp[i] - acc[i], 32'd3);
      checkOutput($sformatf("b2b_rdata%0d", i), rdv[i], b2b_exp[i]);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
